// File: rtl/dot_prod_ctrl.sv
// Operand sequencer and accumulator for an external registered 8x8 multiplier.
// Accepts LEN (a,b) byte pairs, feeds each pair to the multiplier and sums the
// returned 16-bit products into one dot-product result. The result is offered
// on a valid/ready port together with a sticky overflow flag.
module dot_prod_ctrl #(
  parameter int unsigned LEN     = 8,
  parameter int unsigned ACC_W   = 19,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf
);

  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {
    ST_ACC,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [MUL_LAT:0]   r_v;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W:0]     w_sum;
  logic               w_accept;
  logic               w_last_accept;
  logic               w_prod_ok;
  logic               w_last_prod;
  logic               w_hs;

  assign in_ready      = rst_n && (r_state == ST_ACC);
  assign w_accept      = in_valid && in_ready;
  assign w_last_accept = w_accept && (r_cnt == LAST_CNT);
  assign w_prod_ok     = r_v[MUL_LAT];
  // No accepts happen in DRAIN, so the final product is the one reaching the
  // pipeline output with every earlier stage already empty.
  assign w_last_prod   = (r_state == ST_DRAIN) && r_v[MUL_LAT] && !(|r_v[MUL_LAT-1:0]);
  assign w_hs          = res_valid && res_ready;
  assign w_sum         = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, mul_p};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACC;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC:   if (w_last_accept) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_prod)   w_state_nxt = ST_DONE;
      ST_DONE:  if (w_hs)          w_state_nxt = ST_ACC;
      default:                     w_state_nxt = ST_ACC;
    endcase
  end

  // Operand registers toward the multiplier; zero when nothing is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (w_accept) begin
      mul_a <= in_a;
      mul_b <= in_b;
    end else begin
      mul_a <= '0;
      mul_b <= '0;
    end
  end

  // Valid flags tracking each pair through the multiplier latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_v <= '0;
    else        r_v <= {r_v[MUL_LAT-1:0], w_accept};
  end

  // Accept counter within a vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      if (r_cnt == LAST_CNT) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
    end
  end

  // Accumulator: adds each valid product, cleared once the result is taken out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_prod_ok) begin
      if (w_last_prod) r_acc <= '0;
      else             r_acc <= w_sum[ACC_W-1:0];
    end
  end

  // Result register and valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_valid <= 1'b0;
    end else if (w_last_prod) begin
      res_data  <= w_sum[ACC_W-1:0];
      res_valid <= 1'b1;
    end else if (w_hs) begin
      res_valid <= 1'b0;
    end
  end

  // Sticky overflow flag, cleared by the result handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ovf <= 1'b0;
    end else if (w_hs) begin
      res_ovf <= 1'b0;
    end else if (w_prod_ok && w_sum[ACC_W]) begin
      res_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dot_prod_ctrl.sv
// Scoreboard bench for dot_prod_ctrl: two instances (ACC_W=19 and ACC_W=16)
// share one stimulus stream, each with its own multiplier model and queue.
module tb_dot_prod_ctrl;

  localparam int unsigned LEN     = 8;
  localparam int unsigned MUL_LAT = 1;
  localparam int unsigned W0      = 19;
  localparam int unsigned W1      = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic [31:0] edge_no;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        res_ready = 1'b0;

  logic        in_ready0, in_ready1;
  logic [7:0]  mul_a0, mul_b0, mul_a1, mul_b1;
  logic [15:0] mul_p0, mul_p1;
  logic        res_valid0, res_valid1;
  logic [W0-1:0] res_data0;
  logic [W1-1:0] res_data1;
  logic        res_ovf0, res_ovf1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned edge_n   = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned m_sum = 0;
  int unsigned m_cnt = 0;
  bit          busy = 1'b0;
  int          rr_mode = 1;
  int unsigned rv_cnt = 0;

  bit          pv[2];
  logic [31:0] hd[2];
  logic        ho[2];

  logic [7:0]  va[LEN];
  logic [7:0]  vb[LEN];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  dot_prod_ctrl #(.LEN(LEN), .ACC_W(W0), .MUL_LAT(MUL_LAT)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0),
    .res_valid(res_valid0), .res_ready(res_ready), .res_data(res_data0), .res_ovf(res_ovf0)
  );

  dot_prod_ctrl #(.LEN(LEN), .ACC_W(W1), .MUL_LAT(MUL_LAT)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1),
    .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1), .res_ovf(res_ovf1)
  );

  // Registered multiplier models, MUL_LAT stages each
  logic [15:0] mp0[MUL_LAT];
  logic [15:0] mp1[MUL_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        mp0[i] <= '0;
        mp1[i] <= '0;
      end
    end else begin
      mp0[0] <= 16'(mul_a0) * 16'(mul_b0);
      mp1[0] <= 16'(mul_a1) * 16'(mul_b1);
      for (int i = 1; i < MUL_LAT; i++) begin
        mp0[i] <= mp0[i-1];
        mp1[i] <= mp1[i-1];
      end
    end
  end
  assign mul_p0 = mp0[MUL_LAT-1];
  assign mul_p1 = mp1[MUL_LAT-1];

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a dot product is the plain sum of products; the result
  // is that sum modulo 2^W and overflow means the sum reached 2^W.
  task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input int unsigned k);
    exp_t e;
    m_sum = m_sum + 32'(a) * 32'(b);
    m_cnt++;
    if (m_cnt == LEN) begin
      e.data    = m_sum % (32'd1 << W0);
      e.ovf     = (m_sum >= (32'd1 << W0));
      e.edge_no = k + 1 + MUL_LAT;
      q0.push_back(e);
      e.data    = m_sum % (32'd1 << W1);
      e.ovf     = (m_sum >= (32'd1 << W1));
      q1.push_back(e);
      m_sum = 0;
      m_cnt = 0;
      busy  = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_sum = 0;
    m_cnt = 0;
    busy  = 1'b0;
    rv_cnt = 0;
    q0.delete();
    q1.delete();
  endtask

  // One stimulus cycle: inputs change at the falling edge, accept at the next rising edge
  task automatic drive_cycle(input bit v, input logic [7:0] a, input logic [7:0] b, output bit acc);
    @(negedge clk);
    chk("in_ready0", in_ready0, !busy);
    chk("in_ready1", in_ready1, !busy);
    in_valid = v;
    in_a = a;
    in_b = b;
    case (rr_mode)
      0: res_ready = 1'($urandom_range(0, 1));
      1: res_ready = 1'b1;
      default: begin
        if (res_valid0) rv_cnt++;
        else            rv_cnt = 0;
        res_ready = (rv_cnt >= 6);
      end
    endcase
    acc = v && !busy;
    if (acc) model_accept(a, b, edge_n + 1);
    if (res_valid0 && res_ready) busy = 1'b0;
  endtask

  // mode 0: back-to-back, 1: every other cycle, 2: random gaps
  task automatic send_vector(input int mode);
    int unsigned i;
    int unsigned guard;
    bit v;
    bit acc;
    i = 0;
    guard = 0;
    while (i < LEN && guard < 500) begin
      guard++;
      case (mode)
        0: v = 1'b1;
        1: v = guard[0];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (v) drive_cycle(1'b1, va[i], vb[i], acc);
      else   drive_cycle(1'b0, 8'($urandom), 8'($urandom), acc);
      if (acc) i++;
    end
    if (i < LEN) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got %0d accepts expected %0d", i, LEN);
    end
  endtask

  task automatic wait_idle();
    bit acc;
    bit done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      drive_cycle(1'b0, 8'd0, 8'd0, acc);
      done = (q0.size() == 0) && (q1.size() == 0) && !busy && !res_valid0 && !res_valid1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout: got pending %0d/%0d expected 0/0", q0.size(), q1.size());
    end
  endtask

  // Monitor: pops an expectation on each result presentation and checks
  // that the result stays stable and input is blocked while it is held.
  task automatic mon(input int idx, input logic rv, input logic [31:0] rd, input logic ro, input logic ir);
    exp_t e;
    bit got;
    if (rv && !pv[idx]) begin
      got = 1'b0;
      if (idx == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      if (idx == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      if (!got) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result%0d: got %0d expected none", idx, rd);
      end else begin
        chk($sformatf("res_data%0d", idx), rd, e.data);
        chk($sformatf("res_ovf%0d", idx), ro, e.ovf);
        chk($sformatf("latency%0d", idx), edge_n, e.edge_no);
      end
      hd[idx] = rd;
      ho[idx] = ro;
    end else if (rv) begin
      chk($sformatf("hold_data%0d", idx), rd, hd[idx]);
      chk($sformatf("hold_ovf%0d", idx), ro, ho[idx]);
      chk($sformatf("ready_in_done%0d", idx), ir, 0);
    end
    pv[idx] = rv;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pv[0] = 1'b0;
      pv[1] = 1'b0;
    end else begin
      mon(0, res_valid0, 32'(res_data0), res_ovf0, in_ready0);
      mon(1, res_valid1, 32'(res_data1), res_ovf1, in_ready1);
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_mul_a0"}, mul_a0, 0);
    chk({tag, "_mul_b0"}, mul_b0, 0);
    chk({tag, "_res_valid0"}, res_valid0, 0);
    chk({tag, "_res_data0"}, res_data0, 0);
    chk({tag, "_res_ovf0"}, res_ovf0, 0);
    chk({tag, "_in_ready0"}, in_ready0, 0);
    chk({tag, "_mul_a1"}, mul_a1, 0);
    chk({tag, "_res_valid1"}, res_valid1, 0);
    chk({tag, "_res_data1"}, res_data1, 0);
    chk({tag, "_in_ready1"}, in_ready1, 0);
  endtask

  initial begin
    bit acc;

    // Reset held with valid input present: nothing may be accepted
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_a = 8'hA5;
    in_b = 8'h3C;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    in_valid = 1'b0;
    rr_mode = 1;

    // a=b=1..8 back-to-back: 204
    for (int i = 0; i < LEN; i++) begin va[i] = 8'(i + 1); vb[i] = 8'(i + 1); end
    send_vector(0);
    wait_idle();

    // a=b=255: largest products; overflows the 16-bit instance
    for (int i = 0; i < LEN; i++) begin va[i] = 8'd255; vb[i] = 8'd255; end
    send_vector(0);
    // Following small vector must report no overflow
    for (int i = 0; i < LEN; i++) begin va[i] = 8'd2; vb[i] = 8'd3; end
    send_vector(0);
    wait_idle();

    // Gapped input, consumer stalls 5 cycles; next vector presented while result is held
    rr_mode = 2;
    for (int i = 0; i < LEN; i++) begin va[i] = 8'(i + 1); vb[i] = 8'(i + 1); end
    send_vector(1);
    send_vector(0);
    rr_mode = 1;
    wait_idle();

    // Reset in the middle of a vector discards partial work
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(i + 7), 8'(i + 9), acc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    model_reset();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LEN; i++) begin va[i] = 8'(i + 1); vb[i] = 8'(i + 1); end
    send_vector(0);
    wait_idle();

    // Random data, random input gaps, random consumer backpressure
    rr_mode = 0;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < LEN; i++) begin
        va[i] = 8'($urandom);
        vb[i] = 8'($urandom);
      end
      send_vector(2);
    end
    rr_mode = 1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
